fetch_queue: RTL

Instruction fetch front end that produces the instruction words the decode stage classifies and decodes. It owns the program counter, issues word requests to a synchronous-read instruction memory, and buffers returned words with their PCs in a small FIFO. It presents them to decode through a valid/stall handshake, and flushes on branch/jump redirects from later stages. When the queue is empty, decode sees a NOP bubble (32'h0000_0000, `sll $0,$0,0`).

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 93 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Instruction-memory and decode handshake bundle for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    // master is the fetch unit itself; slave is memory plus decode/redirect logic
    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
        input  imem_data, redirect, redirect_pc, dec_stall
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
        output imem_data, redirect, redirect_pc, dec_stall
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : PC owner, imem request issue and {instr, pc} FIFO feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_queue_if.master bus
);
    localparam int         c_ptr_w = $clog2(DEPTH);
    localparam int         c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_inflight_pc;
    logic               r_inflight;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_instr_q [DEPTH];
    logic [31:0]        r_pc_q    [DEPTH];

    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_cnt_w:0]   w_pending;
    logic [31:0]        w_target;

    assign w_valid   = ~rst & (r_count != '0);
    assign w_pop     = w_valid & ~bus.dec_stall & ~bus.redirect;
    assign w_push    = r_inflight & ~bus.redirect;
    // Slots already committed after this cycle's pop; issue only if one remains free
    assign w_pending = {1'b0, r_count}
                     + {{c_cnt_w{1'b0}}, r_inflight}
                     - {{c_cnt_w{1'b0}}, w_pop};
    assign w_issue   = ~rst & ~bus.redirect & (w_pending < c_depth);
    assign w_target  = bus.redirect_pc & ~32'h0000_0003;

    assign bus.imem_req     = w_issue;
    assign bus.imem_addr    = rst ? RESET_PC : r_fetch_pc;
    assign bus.dec_valid    = w_valid;
    assign bus.dec_instr    = w_valid ? r_instr_q[r_head] : 32'h0;
    assign bus.dec_pc       = w_valid ? r_pc_q[r_head] : 32'h0;
    assign bus.dec_pc_plus4 = w_valid ? (r_pc_q[r_head] + 32'd4) : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_inflight    <= 1'b0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
            r_head     <= r_tail;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight_pc <= r_fetch_pc;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (~rst && w_push) begin
            r_instr_q[r_tail] <= bus.imem_data;
            r_pc_q[r_tail]    <= r_inflight_pc;
        end
    end
endmodule
`default_nettype wire
